// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for the debug scan controller.
//   - dbg_state_t : sequencer states
//   - dbg_gnt_t   : last-grant encoding used by the IDLE arbiter
//   - scan_advance: next scan address with wrap to the first address
package dbg_pkg;

    localparam int ADDR_W   = 6;
    localparam int REG_LAST = 31;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN_ISSUE = 3'd1,
        SCAN_CAP   = 3'd2,
        REQ_ISSUE  = 3'd3,
        REQ_CAP    = 3'd4
    } dbg_state_t;

    typedef enum logic {
        GNT_SCAN = 1'b0,
        GNT_REQ  = 1'b1
    } dbg_gnt_t;

    // Step to the next scan address, wrapping from last back to first.
    function automatic logic [ADDR_W-1:0] scan_advance(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] last,
        input logic [ADDR_W-1:0] first
    );
        logic [ADDR_W-1:0] nxt;
        if (addr >= last) begin
            nxt = first;
        end else begin
            nxt = addr + 6'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// dbg_tick_gen: auto-step tick divider.
//   CLK, Reset : clock, asynchronous active-high reset
//   en         : count enable; counter is held at 0 while low
//   tick       : registered one-cycle pulse every TICK_DIV enabled cycles
module dbg_tick_gen #(
    parameter int unsigned TICK_DIV = 32'd50000000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic en,
    output logic tick
);

    logic [31:0] cnt_r;

    // Free-running divider while enabled, pulse on the terminal count
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_r <= 32'd0;
            tick  <= 1'b0;
        end else if (!en) begin
            cnt_r <= 32'd0;
            tick  <= 1'b0;
        end else if (cnt_r == (TICK_DIV - 32'd1)) begin
            cnt_r <= 32'd0;
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + 32'd1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl: sequencer/arbiter for the register-file and data-memory
// debug read ports. Generates the display scan address (auto tick or manual
// StepBtn) and shares the ports with a secondary valid/ready requester.
//   CLK, Reset               : clock, asynchronous active-high reset
//   Mode, Sel, StepBtn       : scan control (auto/manual, reg/mem, step)
//   DispReadReg/Mem          : debug read addresses (0 when not in use)
//   DispRegData/MemData      : debug read data, one-cycle latency
//   ScanAddr/ScanData/Valid  : captured scan result, one-cycle valid pulse
//   ReqValid/Sel/Addr/Ready  : secondary request handshake
//   RspValid/RspData         : secondary response, one-cycle valid pulse
// Build option: define DBG_SCAN_SKIP_R0_EN to skip register 0 in scans.
module debug_scan_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 32'd50000000,
    parameter int unsigned MEM_LAST = 32'd63
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Mode,
    input  logic        Sel,
    input  logic        StepBtn,
    output logic [4:0]  DispReadReg,
    output logic [5:0]  DispReadMem,
    input  logic [31:0] DispRegData,
    input  logic [31:0] DispMemData,
    output logic [5:0]  ScanAddr,
    output logic [31:0] ScanData,
    output logic        ScanValid,
    input  logic        ReqValid,
    input  logic        ReqSel,
    input  logic [5:0]  ReqAddr,
    output logic        ReqReady,
    output logic        RspValid,
    output logic [31:0] RspData
);

    localparam logic [ADDR_W-1:0] MEM_LAST_A = ADDR_W'(MEM_LAST);
    localparam logic [ADDR_W-1:0] REG_LAST_A = ADDR_W'(REG_LAST);
`ifdef DBG_SCAN_SKIP_R0_EN
    localparam logic [ADDR_W-1:0] REG_FIRST  = 6'd1;
`else
    localparam logic [ADDR_W-1:0] REG_FIRST  = 6'd0;
`endif

    dbg_state_t        state_r;
    dbg_gnt_t          last_gnt_r;
    logic              pending_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] scan_cur_r;
    logic              scan_sel_r;
    logic              req_sel_r;
    logic              btn_prev_r;
    logic              sel_prev_r;
    logic              mode_prev_r;
    logic              arm_r;

    logic              tick_s;
    logic              step_rise_s;
    logic              sel_chg_s;
    logic              mode_chg_s;
    logic              pend_set_s;
    logic              addr_rst_s;
    logic              scan_win_s;
    logic              req_win_s;
    logic [ADDR_W-1:0] first_addr_s;
    logic [ADDR_W-1:0] scan_addr_s;
    logic [ADDR_W-1:0] scan_last_s;
    logic [ADDR_W-1:0] scan_first_s;

    dbg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (Mode),
        .tick  (tick_s)
    );

    // Input history for edge/change detection; arm_r masks the first cycle
    // after reset so a Sel/Mode level held through reset is not a change.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            btn_prev_r  <= 1'b0;
            sel_prev_r  <= 1'b0;
            mode_prev_r <= 1'b0;
            arm_r       <= 1'b0;
        end else begin
            btn_prev_r  <= StepBtn;
            sel_prev_r  <= Sel;
            mode_prev_r <= Mode;
            arm_r       <= 1'b1;
        end
    end

    // Pending-scan sources, scan address selection and IDLE arbitration
    always_comb begin
        step_rise_s  = StepBtn & ~btn_prev_r;
        sel_chg_s    = arm_r & (Sel ^ sel_prev_r);
        mode_chg_s   = arm_r & (Mode ^ mode_prev_r);
        pend_set_s   = (tick_s & Mode) | (step_rise_s & ~Mode) | sel_chg_s | mode_chg_s;
        addr_rst_s   = sel_chg_s | ~arm_r;
        first_addr_s = Sel ? 6'd0 : REG_FIRST;
        scan_addr_s  = addr_rst_s ? first_addr_s : next_addr_r;
        scan_last_s  = scan_sel_r ? MEM_LAST_A : REG_LAST_A;
        scan_first_s = scan_sel_r ? 6'd0 : REG_FIRST;
        // Tie goes to whichever source was not granted last time.
        scan_win_s   = pending_r & (~ReqValid | (last_gnt_r == GNT_REQ));
        req_win_s    = ReqValid & ~scan_win_s;
    end

    // Sequencer: state, pending flag, scan address and all registered outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            last_gnt_r  <= GNT_SCAN;
            pending_r   <= 1'b1;
            next_addr_r <= REG_FIRST;
            scan_cur_r  <= 6'd0;
            scan_sel_r  <= 1'b0;
            req_sel_r   <= 1'b0;
            DispReadReg <= 5'd0;
            DispReadMem <= 6'd0;
            ScanAddr    <= 6'd0;
            ScanData    <= 32'd0;
            ScanValid   <= 1'b0;
            ReqReady    <= 1'b0;
            RspValid    <= 1'b0;
            RspData     <= 32'd0;
        end else begin
            ScanValid <= 1'b0;
            ReqReady  <= 1'b0;
            RspValid  <= 1'b0;

            // Entry into SCAN_ISSUE consumes the flag; a same-cycle set
            // event is absorbed by the scan being started.
            if (state_r == IDLE && scan_win_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r | pend_set_s;
            end

            // Advance only if Sel is unchanged since the scan was issued;
            // otherwise the Sel change has already restarted the sequence.
            if (addr_rst_s) begin
                next_addr_r <= first_addr_s;
            end else if (state_r == SCAN_CAP && scan_sel_r == Sel) begin
                next_addr_r <= scan_advance(scan_cur_r, scan_last_s, scan_first_s);
            end else begin
                next_addr_r <= next_addr_r;
            end

            case (state_r)
                IDLE: begin
                    if (scan_win_s) begin
                        state_r     <= SCAN_ISSUE;
                        last_gnt_r  <= GNT_SCAN;
                        scan_sel_r  <= Sel;
                        scan_cur_r  <= scan_addr_s;
                        DispReadReg <= Sel ? 5'd0 : scan_addr_s[4:0];
                        DispReadMem <= Sel ? scan_addr_s : 6'd0;
                    end else if (req_win_s) begin
                        state_r     <= REQ_ISSUE;
                        last_gnt_r  <= GNT_REQ;
                        ReqReady    <= 1'b1;
                        req_sel_r   <= ReqSel;
                        DispReadReg <= ReqSel ? 5'd0 : ReqAddr[4:0];
                        DispReadMem <= ReqSel ? ReqAddr : 6'd0;
                    end else begin
                        DispReadReg <= 5'd0;
                        DispReadMem <= 6'd0;
                    end
                end
                SCAN_ISSUE: state_r <= SCAN_CAP;
                SCAN_CAP: begin
                    state_r     <= IDLE;
                    ScanAddr    <= scan_cur_r;
                    ScanData    <= scan_sel_r ? DispMemData : DispRegData;
                    ScanValid   <= 1'b1;
                    DispReadReg <= 5'd0;
                    DispReadMem <= 6'd0;
                end
                REQ_ISSUE: state_r <= REQ_CAP;
                REQ_CAP: begin
                    state_r     <= IDLE;
                    RspData     <= req_sel_r ? DispMemData : DispRegData;
                    RspValid    <= 1'b1;
                    DispReadReg <= 5'd0;
                    DispReadMem <= 6'd0;
                end
                default: begin
                    state_r     <= IDLE;
                    DispReadReg <= 5'd0;
                    DispReadMem <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Directed/randomized bench for debug_scan_ctrl with TICK_DIV = 4.
// Read ports are modelled as arrays of random words; every scan pulse is
// checked against an address-sequence model of the scan rules.
module tb_debug_scan_ctrl;

    localparam int TDIV = 4;
    localparam int MLAST = 63;
`ifdef DBG_SCAN_SKIP_R0_EN
    localparam int REG_FIRST = 1;
`else
    localparam int REG_FIRST = 0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Mode, Sel, StepBtn;
    logic [4:0]  DispReadReg;
    logic [5:0]  DispReadMem;
    logic [31:0] DispRegData, DispMemData;
    logic [5:0]  ScanAddr;
    logic [31:0] ScanData;
    logic        ScanValid;
    logic        ReqValid, ReqSel;
    logic [5:0]  ReqAddr;
    logic        ReqReady, RspValid;
    logic [31:0] RspData;

    logic [31:0] regw [32];
    logic [31:0] memw [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_next;
    logic model_sel;
    int scan_cyc_q[$];
    int rdy_cyc_q[$];
    int rsp_cyc_q[$];
    logic [31:0] rsp_data_q[$];

    always #5 CLK = ~CLK;

    assign DispRegData = regw[DispReadReg];
    assign DispMemData = memw[DispReadMem];

    debug_scan_ctrl #(.TICK_DIV(TDIV), .MEM_LAST(MLAST)) dut (
        .CLK(CLK), .Reset(Reset), .Mode(Mode), .Sel(Sel), .StepBtn(StepBtn),
        .DispReadReg(DispReadReg), .DispReadMem(DispReadMem),
        .DispRegData(DispRegData), .DispMemData(DispMemData),
        .ScanAddr(ScanAddr), .ScanData(ScanData), .ScanValid(ScanValid),
        .ReqValid(ReqValid), .ReqSel(ReqSel), .ReqAddr(ReqAddr),
        .ReqReady(ReqReady), .RspValid(RspValid), .RspData(RspData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap_next(input int a, input logic s);
        int last;
        int first;
        last  = s ? MLAST : 31;
        first = s ? 0 : REG_FIRST;
        return (a >= last) ? first : a + 1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rreg"}, 32'(DispReadReg), 32'd0);
        chk({tag, "_rmem"}, 32'(DispReadMem), 32'd0);
        chk({tag, "_saddr"}, 32'(ScanAddr), 32'd0);
        chk({tag, "_sdata"}, ScanData, 32'd0);
        chk({tag, "_svalid"}, 32'(ScanValid), 32'd0);
        chk({tag, "_rdy"}, 32'(ReqReady), 32'd0);
        chk({tag, "_rspv"}, 32'(RspValid), 32'd0);
        chk({tag, "_rspd"}, RspData, 32'd0);
    endtask

    task automatic step_btn();
        StepBtn = 1'b1;
        repeat (2) @(posedge CLK);
        #1 StepBtn = 1'b0;
        repeat ($urandom_range(6, 8)) @(posedge CLK);
        #1;
    endtask

    // Event monitor: logs handshake pulses and checks every scan result
    always @(negedge CLK) begin
        cyc++;
        if (ScanValid === 1'b1) begin
            scan_cyc_q.push_back(cyc);
            chk("scan_addr", 32'(ScanAddr), 32'(model_next));
            chk("scan_data", ScanData, model_sel ? memw[model_next] : regw[model_next[4:0]]);
            model_next = wrap_next(model_next, model_sel);
        end
        if (ReqReady === 1'b1) rdy_cyc_q.push_back(cyc);
        if (RspValid === 1'b1) begin
            rsp_cyc_q.push_back(cyc);
            rsp_data_q.push_back(RspData);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int q0, q1, r0, p0, n, c_start, cnt, got, ok;
        logic [31:0] exp;

        for (int i = 0; i < 32; i++) regw[i] = $urandom;
        for (int i = 0; i < 64; i++) memw[i] = $urandom;
        Reset = 1'b1; Mode = 1'b0; Sel = 1'b0; StepBtn = 1'b0;
        ReqValid = 1'b0; ReqSel = 1'b0; ReqAddr = 6'd0;
        model_sel = 1'b0; model_next = REG_FIRST;

        // Reset state and first automatic scan after release
        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset");
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("first_issue_addr", 32'(DispReadReg), 32'(REG_FIRST));
        chk("first_valid_c1", 32'(ScanValid), 32'd0);
        @(posedge CLK); #1;
        chk("first_valid_c2", 32'(ScanValid), 32'd0);
        @(posedge CLK); #1;
        chk("first_valid_c3", 32'(ScanValid), 32'd1);
        chk("first_addr", 32'(ScanAddr), 32'(REG_FIRST));
        chk("first_data", ScanData, regw[REG_FIRST]);
        @(posedge CLK); #1;
        chk("first_valid_pulse", 32'(ScanValid), 32'd0);
        repeat (4) @(posedge CLK); #1;

        // Manual register scan: 31 steps wrap around the register file
        q0 = scan_cyc_q.size();
        for (int i = 0; i < 31; i++) step_btn();
        chk("reg_step_count", 32'(scan_cyc_q.size() - q0), 32'd31);
        chk("idle_rreg", 32'(DispReadReg), 32'd0);
        chk("idle_rmem", 32'(DispReadMem), 32'd0);

        // Switch to memory: Sel change rescans address 0, then 64 steps
        Sel = 1'b1; model_sel = 1'b1; model_next = 0;
        repeat (8) @(posedge CLK); #1;
        q1 = scan_cyc_q.size();
        chk("sel_change_scan", 32'(q1 - q0 - 31), 32'd1);
        for (int i = 0; i < 64; i++) step_btn();
        chk("mem_step_count", 32'(scan_cyc_q.size() - q1), 32'd64);

        // Auto mode on registers: one scan every TICK_DIV cycles
        q0 = scan_cyc_q.size();
        Sel = 1'b0; Mode = 1'b1; model_sel = 1'b0; model_next = REG_FIRST;
        for (int i = 0; i < 400 && scan_cyc_q.size() < q0 + 33; i++) @(posedge CLK);
        #1 Mode = 1'b0;
        chk("auto_scan_count", 32'(scan_cyc_q.size() >= q0 + 33), 32'd1);
        if (scan_cyc_q.size() >= q0 + 33) begin
            for (int i = q0 + 2; i <= q0 + 32; i++)
                chk("auto_period", 32'(scan_cyc_q[i] - scan_cyc_q[i-1]), 32'(TDIV));
        end
        repeat (10) @(posedge CLK); #1;

        // Requester held valid while manual steps keep a scan pending
        r0 = rdy_cyc_q.size(); p0 = rsp_cyc_q.size(); q0 = scan_cyc_q.size();
        c_start = cyc;
        ReqValid = 1'b1; ReqSel = 1'b1; ReqAddr = 6'd5;
        n = 0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(posedge CLK); #1;
            StepBtn = ~StepBtn;
            if (ReqReady === 1'b1) n++;
        end
        ReqValid = 1'b0; StepBtn = 1'b0;
        repeat (10) @(posedge CLK); #1;
        chk("alt_ready_count", 32'(n), 32'd6);
        chk("alt_rsp_count", 32'(rsp_cyc_q.size() - p0), 32'd6);
        if (n == 6 && rsp_cyc_q.size() - p0 == 6) begin
            cnt = 0;
            for (int j = q0; j < scan_cyc_q.size(); j++)
                if (scan_cyc_q[j] > c_start && scan_cyc_q[j] < rdy_cyc_q[r0]) cnt++;
            chk("alt_first_is_req", 32'(cnt), 32'd0);
            for (int i = 0; i < 6; i++) begin
                chk("alt_rsp_latency", 32'(rsp_cyc_q[p0+i] - rdy_cyc_q[r0+i]), 32'd2);
                chk("alt_rsp_data", rsp_data_q[p0+i], memw[5]);
            end
            for (int i = 0; i < 5; i++) begin
                cnt = 0;
                for (int j = q0; j < scan_cyc_q.size(); j++)
                    if (scan_cyc_q[j] > rdy_cyc_q[r0+i] && scan_cyc_q[j] < rdy_cyc_q[r0+i+1]) cnt++;
                chk("alt_one_scan_between", 32'(cnt), 32'd1);
                chk("alt_spacing", 32'(rdy_cyc_q[r0+i+1] - rdy_cyc_q[r0+i]), 32'd6);
            end
        end

        // Random single requests to either port
        for (int k = 0; k < 6; k++) begin
            ReqSel = 1'($urandom_range(0, 1));
            ReqAddr = 6'($urandom_range(0, 63));
            exp = ReqSel ? memw[ReqAddr] : regw[ReqAddr[4:0]];
            ReqValid = 1'b1;
            got = 0;
            for (int i = 0; i < 10 && got == 0; i++) begin
                @(posedge CLK); #1;
                if (ReqReady === 1'b1) got = 1;
            end
            ReqValid = 1'b0;
            chk("req_ready_seen", 32'(got), 32'd1);
            @(posedge CLK); #1;
            chk("req_rsp_early", 32'(RspValid), 32'd0);
            @(posedge CLK); #1;
            chk("req_rsp_valid", 32'(RspValid), 32'd1);
            chk("req_rsp_data", RspData, exp);
            repeat (3) @(posedge CLK); #1;
        end

        // Reset during REQ_CAP aborts the response
        ReqSel = 1'b0; ReqAddr = 6'($urandom_range(0, 31)); ReqValid = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            @(posedge CLK); #1;
            if (ReqReady === 1'b1) ok = 1;
        end
        ReqValid = 1'b0;
        chk("abort_ready_seen", 32'(ok), 32'd1);
        @(posedge CLK); #1;
        p0 = rsp_cyc_q.size();
        Reset = 1'b1; model_sel = 1'b0; model_next = REG_FIRST;
        #1 chk_all_zero("abort_async");
        repeat (2) @(posedge CLK); #1;
        chk_all_zero("abort_hold");
        q0 = scan_cyc_q.size();
        Reset = 1'b0;
        repeat (10) @(posedge CLK); #1;
        chk("abort_no_rsp", 32'(rsp_cyc_q.size() - p0), 32'd0);
        chk("abort_reset_scan", 32'(scan_cyc_q.size() - q0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_scan_ctrl.md
# debug_scan_ctrl

Sequencer and arbiter for the debug read ports of the multicycle MIPS register file and data memory. It generates the scan address for the 7-segment display, either auto-stepped on a divided tick or manually stepped by a button. It also shares the same ports with a secondary requester, such as a trace or dump engine, through a valid/ready handshake. It sits between the board I/O, the display driver and the datapath debug ports.

## Interface
Parameters:
- TICK_DIV, 50000000: CLK cycles per auto-step tick; legal range 2..2^32-1.
- MEM_LAST, 63: last data-memory word address; register last address fixed at 31.

Ports (clock and reset first):
- CLK  in  1  system clock; every register is updated on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mode  in  1  0 = manual step, 1 = auto step.
- Sel  in  1  0 = register file, 1 = data memory.
- StepBtn  in  1  debounced level; a rising edge requests one step.
- DispReadReg  out  5  register debug read address.
- DispReadMem  out  6  memory debug read address.
- DispRegData  in  32  register debug read data.
- DispMemData  in  32  memory debug read data.
- ScanAddr  out  6  address currently shown on the display.
- ScanData  out  32  data captured for ScanAddr.
- ScanValid  out  1  one-cycle pulse when ScanData updates.
- ReqValid  in  1  secondary read request.
- ReqSel  in  1  secondary port select (0 = reg, 1 = mem).
- ReqAddr  in  6  secondary address; only [4:0] is used when ReqSel = 0.
- ReqReady  out  1  request accepted in this cycle.
- RspValid  out  1  one-cycle pulse; RspData is valid.
- RspData  out  32  secondary read data.

## Operation
- States: IDLE, SCAN_ISSUE, SCAN_CAP, REQ_ISSUE, REQ_CAP.
- Both read ports have a fixed one-cycle latency. The address is driven in the ISSUE state and the data is sampled at the end of the CAP state.
- In any state other than ISSUE or CAP, the unused port address is 0.
- Pending scan flag:
  - Set by an auto tick when Mode = 1.
  - Set by a StepBtn rising edge when Mode = 0.
  - Set after reset, after a Sel change and after a Mode change.
  - Cleared on entry to SCAN_ISSUE. It is never dropped.
- Scan sequence:
  - SCAN_ISSUE drives the next address.
  - SCAN_CAP latches ScanAddr and ScanData and pulses ScanValid.
  - The address then advances, wrapping 31->0 for registers and MEM_LAST->0 for memory.
- A Sel change resets the next scan address to 0 (see Configuration) and sets pending.
- Request sequence:
  - The IDLE->REQ_ISSUE transition asserts ReqReady for one cycle; ReqSel and ReqAddr are registered in that cycle.
  - REQ_CAP asserts RspValid and RspData.
  - The requester must hold ReqValid, ReqSel and ReqAddr stable until ReqReady.
- Arbitration in IDLE:
  - If only one source is pending, it wins.
  - If both are pending, the source not granted last time wins (alternating). The last-grant bit resets to "scan", so the requester wins the first tie.
- The tick counter free-runs while Mode = 1. It is held at 0 while Mode = 0.
- A tick arriving while a scan is already pending is absorbed; ticks are not counted.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; next scan address 0; last-grant = scan; tick counter 0; pending = 1.
  - Result: the first scan (address 0) starts on the first edge after Reset deasserts.
- Scan: pending -> ScanValid in 3 cycles (IDLE->SCAN_ISSUE->SCAN_CAP->pulse on exit).
- Request: ReqReady cycle N, RspValid cycle N+2; at most one request every 3 cycles.
- The first tick occurs TICK_DIV cycles after entering Mode = 1.
- A StepBtn edge in the same cycle as a tick produces one pending scan.
- Reset mid-transaction aborts it: no ScanValid or RspValid pulse, and the requester must re-issue.

## Configuration
- DBG_SCAN_SKIP_R0_EN defined:
  - In register mode, the scan address skips $zero: register wrap is 31->1, and the reset and Sel-change address is 1.
  - Memory mode and secondary requests are unchanged; ReqAddr 0 is still served.
- Not defined: all 32 registers are scanned, as described above.

## Structure
- Package dbg_pkg holds:
  - the state enum;
  - REG_LAST = 31;
  - the address width of 6;
  - the grant encoding (GNT_SCAN, GNT_REQ).
- One sub-module, dbg_tick_gen: a TICK_DIV counter with an enable input and a one-cycle tick output.

## Test plan
- Reset release with Mode = 0, Sel = 0 -> DispReadReg = 0 in cycle 1, ScanValid in cycle 3 with ScanAddr = 0 and ScanData = DispRegData[0].
- Mode = 0, Sel = 1, 64 StepBtn pulses -> ScanAddr runs 1..63 then 0; exactly 64 ScanValid pulses.
- Mode = 1, TICK_DIV = 4 -> one ScanValid every 4 cycles; ScanAddr cycles 0..31 and back to 0.
- ReqValid held continuously with auto scan pending every cycle -> grants alternate REQ, SCAN, REQ, ...; RspValid comes 2 cycles after each ReqReady, with RspData equal to the memory word at ReqAddr = 5.
- Reset asserted during REQ_CAP -> no RspValid; all outputs are 0 while reset is high.
- With DBG_SCAN_SKIP_R0_EN, Sel = 0, 31 steps after reset -> ScanAddr runs 1..31 then 1; register 0 is never driven by a scan.
